// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared state type, CSR layout and FP32 ordering helpers for the softmax row buffer
package softmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_REPLAY = 2'd2
  } state_e;

  localparam int CSR_FUNC_MSB   = 31;
  localparam int CSR_FUNC_LSB   = 26;
  localparam int CSR_PASSES_MSB = 25;
  localparam int CSR_PASSES_LSB = 24;
  localparam int CSR_BEATS_LSB  = 0;
  localparam int FUNC_START_BIT = 4;

  localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;

  // Monotonic unsigned key: -0 sorts below +0 and NaN patterns sort by their bits.
  function automatic logic [31:0] fp32_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/fp32_lane_max.sv
// rtl/fp32_lane_max.sv - combinational FP32 maximum across the lanes of one stream beat
module fp32_lane_max
  import softmax_pkg::*;
#(
  parameter int Lanes = 4
) (
  input  logic [Lanes*32-1:0] lanes_i,
  output logic [31:0]         max_o
);

  always_comb begin
    logic [31:0] best;
    best = lanes_i[31:0];
    for (int k = 1; k < Lanes; k++) begin
      if (fp32_key(lanes_i[k*32 +: 32]) > fp32_key(best)) begin
        best = lanes_i[k*32 +: 32];
      end
    end
    max_o = best;
  end

endmodule

// File: rtl/softmax_row_buffer.sv
// rtl/softmax_row_buffer.sv - buffers one softmax row, tracks its FP32 max and replays it for several passes
module softmax_row_buffer
  import softmax_pkg::*;
#(
  parameter int DataWidth = 128,
  parameter int FpWidth   = 32,
  parameter int Lanes     = DataWidth / FpWidth,
  parameter int MaxBeats  = 32,
  parameter int MaxPasses = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ext_data_i_valid,
  output logic                 ext_data_i_ready,
  input  logic [DataWidth-1:0] ext_data_i_bits,
  output logic                 ext_data_o_valid,
  input  logic                 ext_data_o_ready,
  output logic [DataWidth-1:0] ext_data_o_bits,
  output logic                 ext_last_o,
  output logic [1:0]           ext_pass_o,
  output logic [FpWidth-1:0]   ext_max_o,
  output logic                 ext_max_valid_o,
  input  logic [31:0]          ext_csr_i_0,
  input  logic                 ext_start_i,
  output logic                 ext_busy_o,
  output logic                 ext_done_o,
  output logic                 ext_err_o
);

  localparam int AW = $clog2(MaxBeats);
  localparam int BW = $clog2(MaxBeats) + 1;
  localparam logic [BW-1:0] MAX_BEATS_L  = BW'(MaxBeats);
  localparam logic [1:0]    MAX_PASSES_L = 2'(MaxPasses);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]      pass_q, pass_d;
  logic [31:0]     max_q, max_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic [1:0]      passes_q, passes_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            wr_en;

  logic [DataWidth-1:0] row_mem [MaxBeats];

  logic [5:0]      csr_func;
  logic [1:0]      cfg_passes;
  logic [BW-1:0]   cfg_beats;
  logic            cfg_ok;
  logic [BW-1:0]   beats_m1;
  logic            load_last, rd_last, in_hs, out_hs;
  logic [31:0]     beat_max;
  logic            csr_unused;

  assign csr_func   = ext_csr_i_0[CSR_FUNC_MSB:CSR_FUNC_LSB];
  assign cfg_passes = ext_csr_i_0[CSR_PASSES_MSB:CSR_PASSES_LSB];
  assign cfg_beats  = ext_csr_i_0[CSR_BEATS_LSB +: BW];
  assign csr_unused = ^ext_csr_i_0;
  assign cfg_ok     = (cfg_beats != '0) && (cfg_beats <= MAX_BEATS_L) &&
                      (cfg_passes != '0) && (cfg_passes <= MAX_PASSES_L);

  assign beats_m1  = beats_q - BW'(1);
  assign load_last = ({1'b0, wr_ptr_q} == beats_m1);
  assign rd_last   = ({1'b0, rd_ptr_q} == beats_m1);
  assign in_hs     = ext_data_i_valid && ext_data_i_ready;
  assign out_hs    = ext_data_o_valid && ext_data_o_ready;

  fp32_lane_max #(.Lanes(Lanes)) u_lane_max (
    .lanes_i (ext_data_i_bits[Lanes*32-1:0]),
    .max_o   (beat_max)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pass_d   = pass_q;
    max_d    = max_q;
    beats_d  = beats_q;
    passes_d = passes_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ext_start_i && csr_func[FUNC_START_BIT]) begin
          if (cfg_ok) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pass_d   = '0;
            max_d    = FP32_NEG_INF;
            beats_d  = cfg_beats;
            passes_d = cfg_passes;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (in_hs) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (fp32_key(beat_max) > fp32_key(max_q)) begin
            max_d = beat_max;
          end
          if (load_last) begin
            state_d  = ST_REPLAY;
            rd_ptr_d = '0;
            pass_d   = '0;
          end
        end
      end
      ST_REPLAY: begin
        if (out_hs) begin
          if (rd_last) begin
            rd_ptr_d = '0;
            if (pass_q == passes_q - 2'd1) begin
              state_d = ST_IDLE;
              pass_d  = '0;
              done_d  = 1'b1;
            end else begin
              pass_d = pass_q + 2'd1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      max_q    <= '0;
      beats_q  <= '0;
      passes_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pass_q   <= pass_d;
      max_q    <= max_d;
      beats_q  <= beats_d;
      passes_q <= passes_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Row storage is left unreset; its contents are only visible while replaying.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      row_mem[wr_ptr_q] <= ext_data_i_bits;
    end
  end

  assign ext_data_i_ready = (state_q == ST_LOAD);
  assign ext_data_o_valid = (state_q == ST_REPLAY);
  assign ext_data_o_bits  = (state_q == ST_REPLAY) ? row_mem[rd_ptr_q] : '0;
  assign ext_last_o       = (state_q == ST_REPLAY) && rd_last;
  assign ext_pass_o       = pass_q;
  assign ext_max_o        = max_q;
  assign ext_max_valid_o  = (state_q == ST_REPLAY);
  assign ext_busy_o       = (state_q != ST_IDLE);
  assign ext_done_o       = done_q;
  assign ext_err_o        = err_q;

endmodule
